rptr_empty_fwft: RTL and testbench

- Read-side controller for the dual-clock FIFO; the counterpart of the write-pointer/full logic.
- Runs entirely in the read clock domain.
- Maintains the binary and Gray read pointers and the registered empty flag.
- Fronts the FIFO memory with a first-word-fall-through output register using a valid/ready handshake.
- Reports occupancy and an almost-empty flag derived from the synchronized write pointer.

---
 rtl/rptr_empty_fwft.sv | 85 ++++++++
 tb/tb_rptr_empty_fwft.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rptr_empty_fwft.sv
// Read-side controller for a dual-clock FIFO: binary/Gray read pointers, registered
// empty flag, first-word-fall-through output register, and occupancy/almost-empty reporting.
module rptr_empty_fwft #(
  parameter int ADDRSIZE = 4,
  parameter int DATASIZE = 8,
  parameter int AE_LEVEL = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   wptr_rclk,
  input  logic [DATASIZE-1:0] rmem_data,
  input  logic                rready,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic [ADDRSIZE+1:0] rlevel,
  output logic                ralmost_empty
);

  localparam logic [ADDRSIZE+1:0] AE_THRESH = (ADDRSIZE+2)'(AE_LEVEL);

  logic [ADDRSIZE:0]   rbin;
  logic [ADDRSIZE:0]   n_rbin;
  logic [ADDRSIZE:0]   n_rptr;
  logic [ADDRSIZE:0]   wbin_rclk;
  logic [ADDRSIZE:0]   mem_count;
  logic [ADDRSIZE+1:0] n_rlevel;
  logic                rpop;
  logic                n_rvalid;

  assign raddr = rbin[ADDRSIZE-1:0];

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    wbin_rclk = '0;
    n_rvalid  = rvalid;

    // Pop from memory whenever a word exists and the output register is free or being drained.
    rpop   = ~rempty & (~rvalid | rready);
    n_rbin = rbin + {{ADDRSIZE{1'b0}}, rpop};
    n_rptr = (n_rbin >> 1) ^ n_rbin;

    if (rpop) begin
      n_rvalid = 1'b1;
    end else if (rready) begin
      n_rvalid = 1'b0;
    end

    // Gray-to-binary: each bit is the XOR of itself and every more significant bit.
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin_rclk[i] = ^(wptr_rclk >> i);
    end

    mem_count = wbin_rclk - n_rbin;
    n_rlevel  = {1'b0, mem_count} + {{(ADDRSIZE+1){1'b0}}, n_rvalid};
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
  // NOTE: the asynchronous reset clears every flop here; there is no storage array to leave unreset.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      rdata         <= '0;
      rvalid        <= 1'b0;
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
    end else begin
      rbin          <= n_rbin;
      rptr          <= n_rptr;
      // Empty compares Gray codes so a mid-transition synchronized pointer never looks non-empty early.
      rempty        <= (n_rptr == wptr_rclk);
      rvalid        <= n_rvalid;
      rlevel        <= n_rlevel;
      ralmost_empty <= (n_rlevel <= AE_THRESH);
      if (rpop) begin
        rdata <= rmem_data;
      end
    end
  end

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Bench for rptr_empty_fwft: vector table for reset/single-word/backpressure, hand sequences
// for full and mid-stream reset, and a scoreboarded random stream across pointer wrap.
module tb_rptr_empty_fwft;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          rclk = 1'b0;
  logic          rrst;
  logic [AW:0]   wptr_rclk;
  logic [DW-1:0] rmem_data;
  logic          rready;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic [AW+1:0] rlevel;
  logic          ralmost_empty;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] sbq [$];

  int passed = 0;
  int total  = 0;

  always #5 rclk = ~rclk;

  assign rmem_data = mem[raddr];

  rptr_empty_fwft #(.ADDRSIZE(AW), .DATASIZE(DW), .AE_LEVEL(2)) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .wptr_rclk     (wptr_rclk),
    .rmem_data     (rmem_data),
    .rready        (rready),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .rlevel        (rlevel),
    .ralmost_empty (ralmost_empty)
  );

  typedef struct {
    logic          rst;
    logic [AW:0]   wptr;
    logic          rdy;
    logic          mwe;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mdata;
    logic          e_empty;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [AW:0]   e_rptr;
    logic [AW-1:0] e_raddr;
    logic [AW+1:0] e_level;
    logic          e_ae;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [AW:0] b2g(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] g2b(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_row(input int r, input vec_t v);
    check($sformatf("row%0d rempty", r), 32'(rempty), 32'(v.e_empty));
    check($sformatf("row%0d rvalid", r), 32'(rvalid), 32'(v.e_valid));
    check($sformatf("row%0d rdata", r), 32'(rdata), 32'(v.e_data));
    check($sformatf("row%0d rptr", r), 32'(rptr), 32'(v.e_rptr));
    check($sformatf("row%0d raddr", r), 32'(raddr), 32'(v.e_raddr));
    check($sformatf("row%0d rlevel", r), 32'(rlevel), 32'(v.e_level));
    check($sformatf("row%0d ralmost_empty", r), 32'(ralmost_empty), 32'(v.e_ae));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " rempty"}, 32'(rempty), 32'd1);
    check({tag, " rvalid"}, 32'(rvalid), 32'd0);
    check({tag, " rptr"}, 32'(rptr), 32'd0);
    check({tag, " raddr"}, 32'(raddr), 32'd0);
    check({tag, " rdata"}, 32'(rdata), 32'd0);
    check({tag, " rlevel"}, 32'(rlevel), 32'd0);
    check({tag, " ralmost_empty"}, 32'(ralmost_empty), 32'd1);
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  initial begin
    vec_t        v;
    logic [AW:0] wb;
    logic [AW:0] prev;
    logic [DW-1:0] d;
    int          written;
    int          received;
    int          bad_hd;
    int          wraps;
    int          exp_level;

    rrst      = 1'b1;
    wptr_rclk = '0;
    rready    = 1'b0;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;

    //            rst wptr     rdy mwe ad dat     emp val dat     rptr     ad lvl ae
    tbl[0]  = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd0, 8'hA5, 1'b1, 1'b0, 8'h00, 5'b00000, 4'd0, 6'd0, 1'b1};
    tbl[1]  = '{1'b0, 5'b00001, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00000, 4'd0, 6'd1, 1'b1};
    tbl[2]  = '{1'b0, 5'b00001, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'hA5, 5'b00001, 4'd1, 6'd1, 1'b1};
    tbl[3]  = '{1'b0, 5'b00001, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'b00001, 4'd1, 6'd0, 1'b1};
    tbl[4]  = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd0, 8'h11, 1'b1, 1'b0, 8'h00, 5'b00000, 4'd0, 6'd0, 1'b1};
    tbl[5]  = '{1'b0, 5'b00000, 1'b0, 1'b1, 4'd1, 8'h22, 1'b1, 1'b0, 8'h00, 5'b00000, 4'd0, 6'd0, 1'b1};
    tbl[6]  = '{1'b0, 5'b00010, 1'b0, 1'b1, 4'd2, 8'h33, 1'b0, 1'b0, 8'h00, 5'b00000, 4'd0, 6'd3, 1'b0};
    tbl[7]  = '{1'b0, 5'b00010, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h11, 5'b00001, 4'd1, 6'd3, 1'b0};
    tbl[8]  = '{1'b0, 5'b00010, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h11, 5'b00001, 4'd1, 6'd3, 1'b0};
    tbl[9]  = '{1'b0, 5'b00010, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h22, 5'b00011, 4'd2, 6'd2, 1'b1};
    tbl[10] = '{1'b0, 5'b00010, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'h33, 5'b00010, 4'd3, 6'd1, 1'b1};
    tbl[11] = '{1'b0, 5'b00010, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 8'h33, 5'b00010, 4'd3, 6'd0, 1'b1};

    // Reset, single word and backpressure vectors; reset rows are checked without a clock edge.
    for (int r = 0; r < 12; r++) begin
      v = tbl[r];
      wptr_rclk = v.wptr;
      rready    = v.rdy;
      if (v.mwe) mem[v.maddr] = v.mdata;
      if (v.rst) begin
        rrst = 1'b1;
        #2;
        check_row(r, v);
        rrst = 1'b0;
      end else begin
        tick();
        check_row(r, v);
      end
    end

    // Full memory: 16 words written, then drained continuously.
    rready = 1'b0;
    rrst   = 1'b1;
    for (int i = 0; i < 2**AW; i++) mem[i] = 8'h80 + 8'(i);
    wptr_rclk = '0;
    #2;
    rrst      = 1'b0;
    wptr_rclk = 5'b11000;
    tick();
    check("full rempty", 32'(rempty), 32'd0);
    check("full rlevel", 32'(rlevel), 32'd16);
    check("full ralmost_empty", 32'(ralmost_empty), 32'd0);
    tick();
    check("full first rvalid", 32'(rvalid), 32'd1);
    check("full first rdata", 32'(rdata), 32'h80);
    check("full first rlevel", 32'(rlevel), 32'd16);
    check("full first ralmost_empty", 32'(ralmost_empty), 32'd0);
    rready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_level = 16 - k;
      check($sformatf("drain%0d rlevel", k), 32'(rlevel), 32'(exp_level));
      check($sformatf("drain%0d ralmost_empty", k), 32'(ralmost_empty), 32'(exp_level <= 2));
      if (k <= 15) check($sformatf("drain%0d rdata", k), 32'(rdata), 32'h80 + 32'(k));
      else         check("drain end rvalid", 32'(rvalid), 32'd0);
    end
    check("drain end rempty", 32'(rempty), 32'd1);
    check("drain end rptr", 32'(rptr), 32'b11000);

    // Reset mid-stream with a word in the output register and five words outstanding.
    rready = 1'b0;
    rrst   = 1'b1;
    for (int i = 0; i < 2**AW; i++) mem[i] = 8'h40 + 8'(i);
    wptr_rclk = '0;
    #2;
    rrst      = 1'b0;
    wptr_rclk = b2g(5'd5);
    tick();
    tick();
    check("midrst pre rvalid", 32'(rvalid), 32'd1);
    check("midrst pre rdata", 32'(rdata), 32'h40);
    check("midrst pre rlevel", 32'(rlevel), 32'd5);
    rrst = 1'b1;
    #1;
    check_reset_vals("midrst");
    wptr_rclk = '0;
    #1;
    rrst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post-reset%0d rempty", k), 32'(rempty), 32'd1);
      check($sformatf("post-reset%0d rvalid", k), 32'(rvalid), 32'd0);
    end

    // Random stream of 70 words across two pointer wraps, checked against the scoreboard queue.
    wb       = '0;
    prev     = rptr;
    written  = 0;
    received = 0;
    bad_hd   = 0;
    wraps    = 0;
    for (int cyc = 0; cyc < 3000 && received < 70; cyc++) begin
      if (rptr !== prev) begin
        if ($countones(rptr ^ prev) != 1) bad_hd++;
        if (prev == 5'b10000 && rptr == 5'b00000) wraps++;
        prev = rptr;
      end
      rready = ($urandom_range(0, 3) != 0);
      if (rvalid && rready) begin
        if (sbq.size() == 0) check("stream spurious rvalid", 32'(rvalid), 32'd0);
        else check($sformatf("stream word%0d", received), 32'(rdata), 32'(sbq.pop_front()));
        received++;
      end
      if (written < 70 && $urandom_range(0, 2) != 0 && ((wb - g2b(rptr)) < 5'd16)) begin
        d = 8'($urandom_range(0, 255));
        mem[wb[AW-1:0]] = d;
        sbq.push_back(d);
        wb        = wb + 5'd1;
        wptr_rclk = b2g(wb);
        written++;
      end
      tick();
    end
    check("stream words received", 32'(received), 32'd70);
    check("stream queue drained", 32'(sbq.size()), 32'd0);
    check("stream gray hamming errors", 32'(bad_hd), 32'd0);
    check("stream rptr wraps", 32'(wraps), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
